// File: rtl/axib_arbiter_pkg.sv
// axib_pkg: shared helpers and FSM state types for the AXI4 N-to-1 arbiter.
package axib_pkg;
    // Width of the port-index prefix; never zero so N_PORTS=1 still carries a 1-bit prefix.
    function automatic int port_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction
    typedef enum logic {WR_IDLE, WR_BUSY} wr_state_t;
    typedef enum logic {RD_IDLE, RD_BUSY} rd_state_t;
endpackage

// File: rtl/axib_arbiter_if.sv
// if_axib: AXI4 bundle (AW, W, B, AR, R).
// Modport m drives the request channels; modport s answers them.
interface if_axib #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8
);
    logic                    awvalid, awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [ID_WIDTH-1:0]     awid;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    wvalid, wready, wlast;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    bvalid, bready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    arvalid, arready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [ID_WIDTH-1:0]     arid;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    rvalid, rready, rlast;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    modport m (
        output awvalid, awaddr, awid, awlen, awsize, awburst, input awready,
        output wvalid, wdata, wstrb, wlast, input wready,
        input bvalid, bid, bresp, output bready,
        output arvalid, araddr, arid, arlen, arsize, arburst, input arready,
        input rvalid, rid, rdata, rresp, rlast, output rready
    );
    modport s (
        input awvalid, awaddr, awid, awlen, awsize, awburst, output awready,
        input wvalid, wdata, wstrb, wlast, output wready,
        output bvalid, bid, bresp, input bready,
        input arvalid, araddr, arid, arlen, arsize, arburst, output arready,
        output rvalid, rid, rdata, rresp, rlast, input rready
    );
endinterface

// File: rtl/axib_arbiter_rr.sv
// rr_arbiter: round-robin grant over N requesters.
// Ports: clk, rst_n, req[N], advance (commit grant), gnt_onehot[N], gnt_idx.
module rr_arbiter import axib_pkg::*; #(
    parameter int N = 2,
    localparam int B = port_bits(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt_onehot,
    output logic [B-1:0] gnt_idx
);
    logic [B-1:0] ptr;
    logic [B-1:0] cand;
    // Scan from the farthest offset down to ptr+1 so the nearest requester wins last.
    always_comb begin
        gnt_idx = '0;
        cand = '0;
        for (int k = N; k >= 1; k--) begin
            cand = B'((32'(ptr) + 32'(k)) % N);
            if (req[cand]) gnt_idx = cand;
        end
        gnt_onehot = (|req) ? (N'(1) << gnt_idx) : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr <= B'(N - 1);
        else if (advance && |req) ptr <= gnt_idx;
    end
endmodule

// File: rtl/axib_arbiter.sv
// axib_arbiter: N-to-1 AXI4 arbiter with independent round-robin on the read and write paths.
// Ports: clk, rst_n (async, active-low), s[N_PORTS] upstream slaves, m downstream master.
// Downstream IDs carry the upstream port index as a prefix; B/R are routed back by it.
module axib_arbiter import axib_pkg::*; #(
    parameter int N_PORTS    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8,
    localparam int PORT_BITS = port_bits(N_PORTS)
) (
    input logic clk,
    input logic rst_n,
    if_axib.s   s [N_PORTS],
    if_axib.m   m
);
    wr_state_t wr_state;
    rd_state_t rd_state;
    logic aw_pend, w_pend, w_done;
    logic [PORT_BITS-1:0] wg, aw_idx, ar_idx, bp, rp;
    logic [N_PORTS-1:0] awv, arv, wv, wl, aw_gnt, ar_gnt, brdy, rrdy;
    logic [2**PORT_BITS-1:0] brdy_x, rrdy_x;
    logic [ADDR_WIDTH-1:0] awaddr_v [N_PORTS], araddr_v [N_PORTS];
    logic [ID_WIDTH-1:0] awid_v [N_PORTS], arid_v [N_PORTS];
    logic [7:0] awlen_v [N_PORTS], arlen_v [N_PORTS];
    logic [2:0] awsize_v [N_PORTS], arsize_v [N_PORTS];
    logic [1:0] awburst_v [N_PORTS], arburst_v [N_PORTS];
    logic [DATA_WIDTH-1:0] wdata_v [N_PORTS];
    logic [DATA_WIDTH/8-1:0] wstrb_v [N_PORTS];
    assign bp = m.bid[ID_WIDTH +: PORT_BITS];
    assign rp = m.rid[ID_WIDTH +: PORT_BITS];
    for (genvar i = 0; i < N_PORTS; i++) begin : g_port
        assign awv[i] = s[i].awvalid;
        assign awaddr_v[i] = s[i].awaddr;
        assign awid_v[i] = s[i].awid;
        assign awlen_v[i] = s[i].awlen;
        assign awsize_v[i] = s[i].awsize;
        assign awburst_v[i] = s[i].awburst;
        assign arv[i] = s[i].arvalid;
        assign araddr_v[i] = s[i].araddr;
        assign arid_v[i] = s[i].arid;
        assign arlen_v[i] = s[i].arlen;
        assign arsize_v[i] = s[i].arsize;
        assign arburst_v[i] = s[i].arburst;
        assign wv[i] = s[i].wvalid;
        assign wl[i] = s[i].wlast;
        assign wdata_v[i] = s[i].wdata;
        assign wstrb_v[i] = s[i].wstrb;
        assign brdy[i] = s[i].bready;
        assign rrdy[i] = s[i].rready;
        // Grants are gated by rst_n so readies drop the moment reset is asserted.
        assign s[i].awready = rst_n && wr_state == WR_IDLE && aw_gnt[i];
        assign s[i].arready = rst_n && rd_state == RD_IDLE && ar_gnt[i];
        assign s[i].wready = w_pend && wg == PORT_BITS'(i) && m.wready;
        assign s[i].bvalid = m.bvalid && bp == PORT_BITS'(i);
        assign s[i].bid = m.bid[ID_WIDTH-1:0];
        assign s[i].bresp = m.bresp;
        assign s[i].rvalid = m.rvalid && rp == PORT_BITS'(i);
        assign s[i].rid = m.rid[ID_WIDTH-1:0];
        assign s[i].rdata = m.rdata;
        assign s[i].rresp = m.rresp;
        assign s[i].rlast = m.rlast;
    end
    // Prefixes beyond N_PORTS-1 see a ready of 1, so stray responses are sunk.
    always_comb begin
        brdy_x = '1;
        rrdy_x = '1;
        brdy_x[N_PORTS-1:0] = brdy;
        rrdy_x[N_PORTS-1:0] = rrdy;
    end
    assign m.bready = brdy_x[bp];
    assign m.rready = rrdy_x[rp];
    rr_arbiter #(.N(N_PORTS)) u_aw_rr (
        .clk(clk), .rst_n(rst_n), .req(awv), .advance(wr_state == WR_IDLE),
        .gnt_onehot(aw_gnt), .gnt_idx(aw_idx)
    );
    rr_arbiter #(.N(N_PORTS)) u_ar_rr (
        .clk(clk), .rst_n(rst_n), .req(arv), .advance(rd_state == RD_IDLE),
        .gnt_onehot(ar_gnt), .gnt_idx(ar_idx)
    );
    // W stays locked to the granted port until its last beat, independent of AW progress.
    assign m.wvalid = w_pend && wv[wg];
    assign m.wdata = wdata_v[wg];
    assign m.wstrb = wstrb_v[wg];
    assign m.wlast = wl[wg];
    assign w_done = m.wvalid && m.wready && m.wlast;
    assign m.awvalid = aw_pend;
    assign m.arvalid = rd_state == RD_BUSY;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state <= WR_IDLE;
            aw_pend <= 1'b0;
            w_pend <= 1'b0;
            wg <= '0;
            m.awaddr <= '0;
            m.awid <= '0;
            m.awlen <= '0;
            m.awsize <= '0;
            m.awburst <= '0;
        end else if (wr_state == WR_IDLE) begin
            if (|awv) begin
                wr_state <= WR_BUSY;
                aw_pend <= 1'b1;
                w_pend <= 1'b1;
                wg <= aw_idx;
                m.awaddr <= awaddr_v[aw_idx];
                m.awid <= {aw_idx, awid_v[aw_idx]};
                m.awlen <= awlen_v[aw_idx];
                m.awsize <= awsize_v[aw_idx];
                m.awburst <= awburst_v[aw_idx];
            end
        end else begin
            if (aw_pend && m.awready) aw_pend <= 1'b0;
            if (w_done) w_pend <= 1'b0;
            if ((!aw_pend || m.awready) && (!w_pend || w_done)) wr_state <= WR_IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= RD_IDLE;
            m.araddr <= '0;
            m.arid <= '0;
            m.arlen <= '0;
            m.arsize <= '0;
            m.arburst <= '0;
        end else if (rd_state == RD_IDLE) begin
            if (|arv) begin
                rd_state <= RD_BUSY;
                m.araddr <= araddr_v[ar_idx];
                m.arid <= {ar_idx, arid_v[ar_idx]};
                m.arlen <= arlen_v[ar_idx];
                m.arsize <= arsize_v[ar_idx];
                m.arburst <= arburst_v[ar_idx];
            end
        end else if (m.arready) begin
            rd_state <= RD_IDLE;
        end
    end
endmodule

// File: tb/tb_axib_arbiter.sv
// tb_axib_arbiter: directed checks of arbitration, W locking, response routing and reset.
module tb_axib_arbiter;
    import axib_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int nvec = 0;
    int nmis = 0;
    always #5 clk = ~clk;
    if_axib #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(8)) s [2] ();
    if_axib #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(9)) m ();
    if_axib #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(8)) s3 [3] ();
    if_axib #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(10)) m3 ();
    axib_arbiter #(.N_PORTS(2)) dut (.clk(clk), .rst_n(rst_n), .s(s), .m(m));
    axib_arbiter #(.N_PORTS(3)) dut3 (.clk(clk), .rst_n(rst_n), .s(s3), .m(m3));
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    initial begin
        s[0].awvalid = 0; s[0].wvalid = 0; s[0].wlast = 0; s[0].arvalid = 0; s[0].bready = 0; s[0].rready = 0;
        s[1].awvalid = 0; s[1].wvalid = 0; s[1].wlast = 0; s[1].arvalid = 0; s[1].bready = 0; s[1].rready = 0;
        s[0].awlen = 0; s[0].awsize = 2; s[0].awburst = 1; s[0].wstrb = 4'hF; s[0].wdata = 0;
        s[1].awlen = 0; s[1].awsize = 2; s[1].awburst = 1; s[1].wstrb = 4'hF; s[1].wdata = 0;
        s[0].arlen = 0; s[0].arsize = 2; s[0].arburst = 1; s[1].arlen = 0; s[1].arsize = 2; s[1].arburst = 1;
        s[0].awid = 0; s[1].awid = 0; s[0].awaddr = 0; s[1].awaddr = 0;
        s[0].arid = 0; s[1].arid = 0; s[0].araddr = 0; s[1].araddr = 0;
        m.awready = 0; m.wready = 0; m.bvalid = 0; m.bid = 0; m.bresp = 0;
        m.arready = 0; m.rvalid = 0; m.rid = 0; m.rdata = 0; m.rresp = 0; m.rlast = 0;
        s3[0].awvalid = 0; s3[0].wvalid = 0; s3[0].arvalid = 0; s3[0].bready = 0; s3[0].rready = 0;
        s3[1].awvalid = 0; s3[1].wvalid = 0; s3[1].arvalid = 0; s3[1].bready = 0; s3[1].rready = 0;
        s3[2].awvalid = 0; s3[2].wvalid = 0; s3[2].arvalid = 0; s3[2].bready = 0; s3[2].rready = 0;
        m3.awready = 0; m3.wready = 0; m3.bvalid = 0; m3.bid = 0; m3.bresp = 0;
        m3.arready = 0; m3.rvalid = 0; m3.rid = 0; m3.rdata = 0; m3.rresp = 0; m3.rlast = 0;
        // Reset: requests during reset must not be acknowledged.
        s[0].awvalid = 1; s[0].arvalid = 1;
        #2;
        chk("rst_awvalid", m.awvalid, 0);
        chk("rst_arvalid", m.arvalid, 0);
        chk("rst_wvalid", m.wvalid, 0);
        chk("rst_awready0", s[0].awready, 0);
        chk("rst_arready0", s[0].arready, 0);
        s[0].awvalid = 0; s[0].arvalid = 0;
        #10 rst_n = 1;
        cyc();
        // Single write from port 1: AW len 3 plus 4 W beats.
        s[1].awvalid = 1; s[1].awaddr = 32'h100; s[1].awid = 8'h01; s[1].awlen = 3;
        #1;
        chk("w1_awready1", s[1].awready, 1);
        chk("w1_awready0", s[0].awready, 0);
        chk("w1_awvalid_pre", m.awvalid, 0);
        cyc();
        s[1].awvalid = 0; m.awready = 1; m.wready = 1; s[1].wvalid = 1;
        #1;
        chk("w1_awvalid", m.awvalid, 1);
        chk("w1_awid", m.awid, 9'h101);
        chk("w1_awaddr", m.awaddr, 32'h100);
        chk("w1_awlen", m.awlen, 3);
        chk("w1_awready_drop", s[1].awready, 0);
        for (int b = 0; b < 4; b++) begin
            s[1].wdata = 32'hA0 + b; s[1].wlast = (b == 3);
            #1;
            chk("w1_wvalid", m.wvalid, 1);
            chk("w1_wdata", m.wdata, 32'hA0 + b);
            chk("w1_wlast", m.wlast, (b == 3));
            chk("w1_wready1", s[1].wready, 1);
            chk("w1_wready0", s[0].wready, 0);
            cyc();
            m.awready = 0;
        end
        s[1].wvalid = 0; s[1].wlast = 0; m.wready = 0;
        #1;
        chk("w1_idle", wr_state_t'(dut.wr_state), WR_IDLE);
        chk("w1_wvalid_end", m.wvalid, 0);
        chk("w1_awvalid_end", m.awvalid, 0);
        // Both ports read continuously: alternating grants 0,1,0,1.
        s[0].arvalid = 1; s[0].arid = 8'h11; s[0].araddr = 32'h1000;
        s[1].arvalid = 1; s[1].arid = 8'h22; s[1].araddr = 32'h2000;
        m.arready = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rd_arready0", s[0].arready, (k % 2 == 0));
            chk("rd_arready1", s[1].arready, (k % 2 == 1));
            cyc();
            chk("rd_arvalid", m.arvalid, 1);
            chk("rd_arid", m.arid, (k % 2 == 1) ? 9'h122 : 9'h011);
            chk("rd_araddr", m.araddr, (k % 2 == 1) ? 32'h2000 : 32'h1000);
            cyc();
        end
        s[0].arvalid = 0; s[1].arvalid = 0; m.arready = 0;
        // W completes before the AW handshake; the next AW must wait for it.
        s[0].awvalid = 1; s[0].awid = 8'h05; s[0].awaddr = 32'h200; s[0].awlen = 1;
        #1;
        chk("w2_awready0", s[0].awready, 1);
        cyc();
        s[0].awvalid = 0; s[0].wvalid = 1; s[0].wdata = 32'hB0; s[0].wlast = 0; m.wready = 1;
        #1;
        chk("w2_wvalid", m.wvalid, 1);
        chk("w2_wready0", s[0].wready, 1);
        chk("w2_awid", m.awid, 9'h005);
        cyc();
        s[0].wdata = 32'hB1; s[0].wlast = 1;
        #1;
        chk("w2_wdata1", m.wdata, 32'hB1);
        chk("w2_wlast", m.wlast, 1);
        cyc();
        s[0].wvalid = 0; s[0].wlast = 0; m.wready = 0;
        s[1].awvalid = 1; s[1].awid = 8'h33; s[1].awaddr = 32'h300;
        #1;
        chk("w2_block_a", s[1].awready, 0);
        chk("w2_busy", wr_state_t'(dut.wr_state), WR_BUSY);
        chk("w2_awvalid_held", m.awvalid, 1);
        cyc();
        m.awready = 1;
        #1;
        chk("w2_block_b", s[1].awready, 0);
        cyc();
        chk("w2_idle", wr_state_t'(dut.wr_state), WR_IDLE);
        chk("w2_awvalid_off", m.awvalid, 0);
        chk("w2_next_grant", s[1].awready, 1);
        s[1].awvalid = 0; m.awready = 0;
        // Response routing by ID prefix.
        m.bvalid = 1; m.bid = 9'h105; m.bresp = 2'b10; s[1].bready = 1; s[0].bready = 0;
        #1;
        chk("b_bvalid1", s[1].bvalid, 1);
        chk("b_bid1", s[1].bid, 8'h05);
        chk("b_bresp1", s[1].bresp, 2'b10);
        chk("b_bvalid0", s[0].bvalid, 0);
        chk("b_bready", m.bready, 1);
        s[1].bready = 0;
        #1;
        chk("b_bready_route", m.bready, 0);
        m.bvalid = 0;
        m.rvalid = 1; m.rid = 9'h0A7; m.rdata = 32'hDEADBEEF; m.rlast = 1; s[0].rready = 1; s[1].rready = 0;
        #1;
        chk("r_rvalid0", s[0].rvalid, 1);
        chk("r_rid0", s[0].rid, 8'hA7);
        chk("r_rlast0", s[0].rlast, 1);
        chk("r_rdata0", s[0].rdata, 32'hDEADBEEF);
        chk("r_rvalid1", s[1].rvalid, 0);
        chk("r_rready", m.rready, 1);
        m.rvalid = 0; m.rlast = 0; s[0].rready = 0;
        // Three ports: prefix 3 is out of range and must be sunk.
        m3.rvalid = 1; m3.rid = 10'h312;
        m3.bvalid = 1; m3.bid = 10'h3C4;
        #1;
        chk("n3_rready_sink", m3.rready, 1);
        chk("n3_bready_sink", m3.bready, 1);
        chk("n3_rvalid0", s3[0].rvalid, 0);
        chk("n3_rvalid1", s3[1].rvalid, 0);
        chk("n3_rvalid2", s3[2].rvalid, 0);
        chk("n3_bvalid2", s3[2].bvalid, 0);
        m3.rid = 10'h2A5;
        #1;
        chk("n3_rvalid2_hit", s3[2].rvalid, 1);
        chk("n3_rid2", s3[2].rid, 8'hA5);
        chk("n3_rready_route", m3.rready, 0);
        m3.rvalid = 0; m3.bvalid = 0;
        // Reset asserted in the middle of a W burst.
        cyc();
        s[1].awvalid = 1; s[1].awid = 8'h44; s[1].awaddr = 32'h400; s[1].awlen = 3;
        cyc();
        s[1].awvalid = 0; m.awready = 1; m.wready = 1; s[1].wvalid = 1; s[1].wdata = 32'hC0;
        cyc();
        m.awready = 0; s[1].wdata = 32'hC1;
        cyc();
        s[1].wdata = 32'hC2;
        #1;
        chk("rst_mid_wvalid_pre", m.wvalid, 1);
        chk("rst_mid_wready_pre", s[1].wready, 1);
        #1 rst_n = 0;
        s[0].arvalid = 1; s[0].awvalid = 1;
        #1;
        chk("rst_mid_wvalid", m.wvalid, 0);
        chk("rst_mid_wready", s[1].wready, 0);
        chk("rst_mid_awvalid", m.awvalid, 0);
        chk("rst_mid_arvalid", m.arvalid, 0);
        chk("rst_mid_arready", s[0].arready, 0);
        chk("rst_mid_awready", s[0].awready, 0);
        cyc();
        chk("rst_mid_awready_edge", s[0].awready, 0);
        s[0].arvalid = 0; s[0].awvalid = 0; s[1].wvalid = 0; m.wready = 0;
        #2 rst_n = 1;
        cyc();
        chk("rel_wr_idle", wr_state_t'(dut.wr_state), WR_IDLE);
        chk("rel_rd_idle", rd_state_t'(dut.rd_state), RD_IDLE);
        chk("rel_wvalid", m.wvalid, 0);
        chk("rel_awvalid", m.awvalid, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
